sync_fifo_flags: RTL and testbench

//  Single-clock, parametrised-width/depth FIFO with fill level, almost-full/almost-empty

---
 rtl/fifo_pkg.sv | 45 ++++
 rtl/sync_fifo_mem.sv | 34 +++
 rtl/sync_fifo_flags.sv | 125 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing helpers and elaboration-time parameter checks
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit above the address.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Level must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`define FIFO_CHECK_DEPTH(depth) \
    if (!fifo_pkg::is_pow2(depth) || ((depth) < 4)) begin : g_bad_depth \
        $error("FIFO depth must be a power of two and at least 4"); \
    end

`define FIFO_CHECK_LEVELS(depth, af, ae) \
    if (((af) < 1) || ((af) > (depth)) || ((ae) < 0) || ((ae) > ((depth) - 1))) begin : g_bad_levels \
        $error("FIFO almost-full/almost-empty thresholds out of range"); \
    end

`endif

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x WIDTH dual-port RAM, one write port, one registered read port
module sync_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; array contents are never visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with level, thresholds and sticky errors; SYNC_FIFO_FWFT_EN selects FWFT reads
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winc,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rinc,
    output logic [WIDTH-1:0]  rdata,
    input  logic              clr_err,
    output logic              wfull,
    output logic              rempty,
    output logic              walmost_full,
    output logic              ralmost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = level_width(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    `FIFO_CHECK_DEPTH(DEPTH)
    `FIFO_CHECK_LEVELS(DEPTH, AF_LEVEL, AE_LEVEL)

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             wr_acc;
    logic             rd_acc;
    logic             mem_re;
    logic             rempty_next;

    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc) begin
            level_next = level + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_next = level - LVL_ONE;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The RAM read register doubles as the one-entry output stage; it refills
    // whenever it is empty or being popped and the RAM still holds words.
    logic out_valid;
    logic out_valid_next;
    logic ram_has_data;

    assign ram_has_data   = (wr_ptr != rd_ptr);
    assign mem_re         = ram_has_data && (!out_valid || rd_acc);
    assign out_valid_next = mem_re || (out_valid && !rd_acc);
    assign rempty_next    = !out_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
        end
    end
`else
    assign mem_re      = rd_acc;
    assign rempty_next = (level_next == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (mem_re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level         <= level_next;
            wfull         <= (level_next == LVL_FULL);
            rempty        <= rempty_next;
            walmost_full  <= (level_next >= LVL_AF);
            ralmost_empty <= (level_next <= LVL_AE);
            overflow      <= (winc && wfull) || (overflow && !clr_err);
            underflow     <= (rinc && rempty) || (underflow && !clr_err);
        end
    end

    sync_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags, standard or SYNC_FIFO_FWFT_EN mode
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             clr_err;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [3:0]       level;
    logic             overflow;
    logic             underflow;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .winc          (winc),
        .wdata         (wdata),
        .rinc          (rinc),
        .rdata         (rdata),
        .clr_err       (clr_err),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] sb [$];
    bit               m_ov;
    bit               m_ovf;
    bit               m_unf;
    logic [WIDTH-1:0] m_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_empty();
`ifdef SYNC_FIFO_FWFT_EN
        return !m_ov;
`else
        return sb.size() == 0;
`endif
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ov    = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, " level"}, 32'(level), 32'(sb.size()));
        check_eq({tag, " wfull"}, 32'(wfull), 32'(sb.size() == DEPTH));
        check_eq({tag, " rempty"}, 32'(rempty), 32'(m_empty()));
        check_eq({tag, " walmost_full"}, 32'(walmost_full), 32'(sb.size() >= AF));
        check_eq({tag, " ralmost_empty"}, 32'(ralmost_empty), 32'(sb.size() <= AE));
        check_eq({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, " underflow"}, 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (m_ov) begin
            check_eq({tag, " rdata"}, 32'(rdata), 32'(sb[0]));
        end
`else
        check_eq({tag, " rdata"}, 32'(rdata), 32'(m_rdata));
`endif
    endtask

    // One clock: drive at negedge, advance the model, check 1 time unit after posedge.
    task automatic step(input string tag, input bit w, input logic [WIDTH-1:0] d,
                        input bit r, input bit clr);
        bit full_b;
        bit empty_b;
        bit wacc;
        bit racc;
        int ram_cnt;
        @(negedge clk);
        winc    = w;
        wdata   = d;
        rinc    = r;
        clr_err = clr;
        full_b  = (sb.size() == DEPTH);
        empty_b = m_empty();
        wacc    = w && !full_b;
        racc    = r && !empty_b;
        m_ovf   = (w && full_b) || (m_ovf && !clr);
        m_unf   = (r && empty_b) || (m_unf && !clr);
`ifdef SYNC_FIFO_FWFT_EN
        ram_cnt = sb.size() - int'(m_ov);
        m_ov    = ((ram_cnt > 0) && (!m_ov || racc)) || (m_ov && !racc);
        if (racc) void'(sb.pop_front());
`else
        ram_cnt = 0;
        if (racc) m_rdata = sb.pop_front();
`endif
        if (wacc) sb.push_back(d);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        winc    = 1'b0;
        rinc    = 1'b0;
        clr_err = 1'b0;
        wdata   = '0;
        model_reset();
        #12;
        check_state("reset");
        check_eq("reset rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("overflow", 1'b1, 8'h09, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_err", 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) step("prefill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("wrap_rw", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH && sb.size() < DEPTH; i++) step("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
        step("clr_full", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) step("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_rw", 1'b1, 8'hBB, 1'b1, 1'b0);
        step("clr_empty", 1'b0, 8'h00, 1'b0, 1'b1);
        step("read_bb", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        winc  = 1'b0;
        rinc  = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        check_eq("async_rst rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        step("post_rst_wr", 1'b1, 8'hCC, 1'b0, 1'b0);
        step("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        step("final_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
